gate_rr_arbiter: RTL



---
 rtl/gate_pkg.sv | 11 +
 rtl/gate_unit.sv | 24 ++
 rtl/gate_rr_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared opcode definitions for the bitwise gate unit and its round-robin front end.
package gate_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } opcode_t;

endpackage

// File: rtl/gate_unit.sv
// Combinational W-bit bitwise gate: AND / OR / XOR / NAND selected by op.
module gate_unit
    import gate_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        unique case (opcode_t'(op))
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/gate_rr_arbiter.sv
// Round-robin arbiter sharing one gate_unit among N requesters; one op per clock,
// result registered and tagged with the served requester's index.
module gate_rr_arbiter
    import gate_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 4,
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [2*N-1:0]   op,
    input  logic [W*N-1:0]   a,
    input  logic [W*N-1:0]   b,
    output logic [N-1:0]     gnt,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_y
);

    logic [IDW-1:0] r_ptr;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_y;

    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_ptr_next;
    logic [1:0]     w_sel_op;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [W-1:0]   w_y;

    // Search starts at r_ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % int'(N)]) begin
                w_found  = 1'b1;
                w_winner = IDW'((int'(r_ptr) + k) % int'(N));
            end
        end
    end

    always_comb begin
        w_ptr_next = '0;
        if (int'(w_winner) != int'(N) - 1) begin
            w_ptr_next = w_winner + 1'b1;
        end
    end

    always_comb begin
        gnt = '0;
        if (w_found && !rst) begin
            gnt[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_sel_op = op[2*int'(w_winner) +: 2];
        w_sel_a  = a[int'(W)*int'(w_winner) +: W];
        w_sel_b  = b[int'(W)*int'(w_winner) +: W];
    end

    gate_unit #(
        .W (W)
    ) u_gate_unit (
        .op (w_sel_op),
        .a  (w_sel_a),
        .b  (w_sel_b),
        .y  (w_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= '0;
        end else if (w_found) begin
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_winner;
            r_rsp_y     <= w_y;
        end else begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;

endmodule
